// File: rtl/ex_muldiv_seq_if.sv
// EX-stage hookup for the iterative RV32M sequencer: request from the pipeline,
// stall/done/result back.
interface ex_muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);

  logic            MdStartE;
  logic [2:0]      Funct3E;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            MdStallE;
  logic            MdDoneE;
  logic [XLEN-1:0] MdResultE;

  // Pipeline (EX stage / hazard unit) side
  modport master (
    output MdStartE, Funct3E, SrcAE, SrcBE, FlushE,
    input  MdStallE, MdDoneE, MdResultE
  );

  // Sequencer side
  modport slave (
    input  MdStartE, Funct3E, SrcAE, SrcBE, FlushE,
    output MdStallE, MdDoneE, MdResultE
  );

endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide beside the EX ALU: shift-add multiplier and
// restoring divider share one 2*XLEN register, sequenced by IDLE/BUSY/DONE.
module ex_muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  ex_muldiv_seq_if.slave md
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned PW    = 2 * XLEN;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [2:0]      op_q, op_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            stall_c;
  logic            done_c;

  // Operand decode for the instruction sitting in EX
  logic            in_div;
  logic            in_a_signed;
  logic            in_b_signed;
  logic            in_sa;
  logic            in_sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_res;

  assign in_div      = md.Funct3E[2];
  assign in_a_signed = (md.Funct3E != F_MULHU) && (md.Funct3E != F_DIVU) &&
                       (md.Funct3E != F_REMU);
  assign in_b_signed = (md.Funct3E == F_MUL) || (md.Funct3E == F_MULH) ||
                       (md.Funct3E == F_DIV) || (md.Funct3E == F_REM);
  assign in_sa       = in_a_signed & md.SrcAE[XLEN-1];
  assign in_sb       = in_b_signed & md.SrcBE[XLEN-1];
  assign mag_a       = in_sa ? ((~md.SrcAE) + XLEN'(1)) : md.SrcAE;
  assign mag_b       = in_sb ? ((~md.SrcBE) + XLEN'(1)) : md.SrcBE;

  // Divides that need no iteration: by zero, and signed most-negative / -1
  assign div_zero    = in_div & (md.SrcBE == '0);
  assign div_ovf     = in_div & ~md.Funct3E[0] & (md.SrcAE == MIN_NEG) &
                       (md.SrcBE == '1);
  assign special_res = div_zero ? (md.Funct3E[1] ? md.SrcAE : '1)
                                : (md.Funct3E[1] ? '0 : MIN_NEG);

  // Multiply step: {hi,lo} holds partial product over the shifting multiplier
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   mul_next;

  assign mul_sum  = {1'b0, prod_q[PW-1:XLEN]} + {1'b0, opnd_q};
  assign mul_next = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]}
                              : {1'b0, prod_q[PW-1:1]};

  // Divide step: {hi,lo} holds partial remainder over the shifting dividend/quotient
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   div_diff;
  logic            div_ge;
  logic [PW-1:0]   div_next;

  assign rem_sh   = prod_q[PW-1:XLEN-1];
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[XLEN];
  assign div_next = {(div_ge ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                     prod_q[XLEN-2:0], div_ge};

  logic [PW-1:0]   step;
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fin_result;

  assign step     = op_q[2] ? div_next : mul_next;
  assign prod_fix = (sa_q ^ sb_q) ? ((~step) + PW'(1)) : step;
  assign quo_fix  = (sa_q ^ sb_q) ? ((~step[XLEN-1:0]) + XLEN'(1)) : step[XLEN-1:0];
  assign rem_fix  = sa_q ? ((~step[PW-1:XLEN]) + XLEN'(1)) : step[PW-1:XLEN];

  // Result select applied to the value produced by the final step
  always_comb begin
    fin_result = prod_fix[XLEN-1:0];
    case (op_q)
      F_MUL:                     fin_result = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: fin_result = prod_fix[PW-1:XLEN];
      F_DIV, F_DIVU:             fin_result = quo_fix;
      F_REM, F_REMU:             fin_result = rem_fix;
      default:                   fin_result = prod_fix[XLEN-1:0];
    endcase
  end

  // Next-state, datapath load and stall/done generation
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    stall_c  = 1'b0;
    done_c   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!md.FlushE && md.MdStartE) begin
          stall_c = 1'b1;
          op_d    = md.Funct3E;
          sa_d    = in_sa;
          sb_d    = in_sb;
          opnd_d  = in_div ? mag_b : mag_a;
          prod_d  = {XLEN'(0), (in_div ? mag_a : mag_b)};
          if (div_zero || div_ovf) begin
            result_d = special_res;
            cnt_d    = '0;
            state_d  = S_DONE;
          end else begin
            cnt_d    = CNT_W'(XLEN);
            state_d  = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        stall_c = 1'b1;
        if (md.FlushE) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          prod_d = step;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_d = fin_result;
            state_d  = S_DONE;
          end
        end
      end

      // Same instruction is still in EX here, so a held start is not a new op
      S_DONE: begin
        done_c  = ~md.FlushE;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
    end
  end

  assign md.MdStallE  = stall_c;
  assign md.MdDoneE   = done_c;
  assign md.MdResultE = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: transaction-level reference model with a
// per-cycle compare, plus literal expectations for the documented corner cases.
module tb_ex_muldiv_seq;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ex_muldiv_seq_if #(.XLEN(XLEN)) md();

  ex_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M results straight from 64-bit integer arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    int          ia, ib;
    longint      sa, sb, ua, ub, p, q;
    logic [63:0] pu;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      F_MUL:    begin p = sa * sb; return p[31:0]; end
      F_MULH:   begin p = sa * sb; return p[63:32]; end
      F_MULHSU: begin p = sa * ub; return p[63:32]; end
      F_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      F_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; q = sa / sb; return q[31:0]; end
      F_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; q = ua / ub; return q[31:0]; end
      F_REM:    begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
      default:  begin if (b == 0) return a; q = ua % ub; return q[31:0]; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  // Reference model: one outstanding op with a known completion cycle
  int          cyc      = 0;
  bit          active   = 1'b0;
  int          done_cyc = 0;
  logic [31:0] exp_val  = '0;
  logic [31:0] shown    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active = 1'b0;
      shown  = '0;
    end else begin
      if (active) begin
        if (cyc == done_cyc || md.FlushE) active = 1'b0;
      end else if (md.MdStartE && !md.FlushE) begin
        active   = 1'b1;
        done_cyc = cyc + (is_special(md.Funct3E, md.SrcAE, md.SrcBE) ? 1 : 33);
        exp_val  = ref_md(md.Funct3E, md.SrcAE, md.SrcBE);
      end
      cyc++;
      if (active && cyc == done_cyc) shown = exp_val;
    end
  end

  // Per-cycle compare of stall, done and result against the model
  always @(negedge clk) begin
    logic es, ed;
    es = active ? (cyc < done_cyc) : (md.MdStartE && !md.FlushE);
    ed = active && (cyc == done_cyc) && !md.FlushE;
    chk("stall", 32'(md.MdStallE), 32'(es));
    chk("done", 32'(md.MdDoneE), 32'(ed));
    chk("result", md.MdResultE, shown);
  end

  task automatic idle(input int n);
    @(posedge clk); #1;
    md.MdStartE = 1'b0;
    md.FlushE   = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  // Present an op, hold it in EX until done, scramble sources while it iterates
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit use_lit, input logic [31:0] lit, input int lat,
                       output int ts);
    bit seen;
    @(posedge clk); #1;
    md.MdStartE = 1'b1;
    md.FlushE   = 1'b0;
    md.Funct3E  = f3;
    md.SrcAE    = a;
    md.SrcBE    = b;
    ts   = cyc;
    seen = 1'b0;
    if (use_lit) chk("model_pin", ref_md(f3, a, b), lit);
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (md.MdDoneE) seen = 1'b1;
      else if (cyc > ts) begin
        md.SrcAE = $urandom;
        md.SrcBE = $urandom;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", 32'(cyc - ts), 32'(lat));
      if (use_lit) chk("result_lit", md.MdResultE, lit);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ts, ts2, t0;
    logic [2:0]  f3;
    logic [31:0] a, b;

    md.MdStartE = 1'b0;
    md.FlushE   = 1'b0;
    md.Funct3E  = '0;
    md.SrcAE    = '0;
    md.SrcBE    = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(md.MdStallE), 32'd0);
    chk("rst_done", 32'(md.MdDoneE), 32'd0);
    chk("rst_result", md.MdResultE, 32'd0);
    rst_n = 1'b1;
    idle(2);

    do_op(F_MUL,    32'd7,         32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 33, ts);
    do_op(F_MULH,   32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 33, ts);
    do_op(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 33, ts);
    do_op(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 33, ts);
    do_op(F_DIV,    32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFD, 33, ts);
    do_op(F_REM,    32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFF, 33, ts);
    do_op(F_DIVU,   32'd100,       32'd7,         1, 32'd14,        33, ts);
    do_op(F_REMU,   32'd100,       32'd7,         1, 32'd2,         33, ts);

    // Flush while iterating: no done, result keeps the REMU value
    @(posedge clk); #1;
    md.MdStartE = 1'b1;
    md.Funct3E  = F_DIVU;
    md.SrcAE    = 32'd1000;
    md.SrcBE    = 32'd3;
    t0 = cyc;
    repeat (10) @(posedge clk);
    #1;
    md.FlushE = 1'b1;
    @(negedge clk);
    chk("flush_cycle", 32'(cyc - t0), 32'd10);
    chk("flush_hold_result", md.MdResultE, 32'd2);
    chk("flush_no_done", 32'(md.MdDoneE), 32'd0);
    do_op(F_MUL, 32'd3, 32'd4, 1, 32'd12, 33, ts);
    chk("flush_restart_cyc", 32'(ts - t0), 32'd11);

    do_op(F_DIV, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, 1, ts);
    do_op(F_REM, 32'd5,         32'd0,         1, 32'd5,         1, ts);
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1, ts);
    do_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         1, ts);
    idle(2);

    // Flush in the DONE cycle suppresses the pulse but the result is loaded
    @(posedge clk); #1;
    md.MdStartE = 1'b1;
    md.Funct3E  = F_DIVU;
    md.SrcAE    = 32'd9;
    md.SrcBE    = 32'd0;
    @(posedge clk); #1;
    md.FlushE = 1'b1;
    @(negedge clk);
    chk("done_flush_pulse", 32'(md.MdDoneE), 32'd0);
    chk("done_flush_result", md.MdResultE, 32'hFFFF_FFFF);
    idle(2);

    // Flush in IDLE blocks a start
    @(posedge clk); #1;
    md.MdStartE = 1'b1;
    md.FlushE   = 1'b1;
    md.Funct3E  = F_MUL;
    md.SrcAE    = 32'd2;
    md.SrcBE    = 32'd2;
    @(negedge clk);
    chk("idle_flush_stall", 32'(md.MdStallE), 32'd0);
    idle(3);

    // Asynchronous reset mid-multiply
    @(posedge clk); #1;
    md.MdStartE = 1'b1;
    md.Funct3E  = F_MUL;
    md.SrcAE    = 32'd9;
    md.SrcBE    = 32'd9;
    repeat (5) @(posedge clk);
    #1;
    rst_n       = 1'b0;
    md.MdStartE = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(md.MdStallE), 32'd0);
    chk("mid_rst_done", 32'(md.MdDoneE), 32'd0);
    chk("mid_rst_result", md.MdResultE, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(40);

    // Back-to-back multiplies
    do_op(F_MUL, 32'd2, 32'd3, 1, 32'd6,  33, ts);
    do_op(F_MUL, 32'd5, 32'd6, 1, 32'd30, 33, ts2);
    chk("b2b_spacing", 32'(ts2 - ts), 32'd34);

    // Randomized ops, including special-divide corners
    for (int i = 0; i < 48; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      do_op(f3, a, b, 0, 32'd0, is_special(f3, a, b) ? 1 : 33, ts);
      if ($urandom_range(0, 3) == 0) idle(2);
    end

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer that sits beside the EX-stage ALU.
- It accepts forwarded operands for an M-extension instruction held in EX and stalls the pipeline while it iterates.
- It presents a registered result with a one-cycle done pulse; the result then enters EX/MEM in place of the ALU result.
- It owns a 32-step shift-add multiplier, a 32-step restoring divider, and the control FSM that sequences both.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.
CNT_W, $clog2(XLEN)+1, width of the step counter; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
MdStartE  input  1  M-instruction valid in EX (held by decode/ID-EX while the instruction stays in EX)
Funct3E  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcAE  input  XLEN  forwarded rs1 value
SrcBE  input  XLEN  forwarded rs2 value
FlushE  input  1  kill the EX instruction (branch mispredict/redirect)
MdStallE  output  1  to hazard unit: freeze PC, IF/ID and ID/EX
MdDoneE  output  1  one-cycle pulse: MdResultE valid this cycle
MdResultE  output  XLEN  registered result

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, counter 0, MdStallE=0, MdDoneE=0, MdResultE=0, internal accumulators 0. Takes effect immediately, including mid-operation. The aborted op never produces MdDoneE.
- States: IDLE, BUSY, DONE.

IDLE:
- If FlushE=1, stay in IDLE and ignore start.
- Else, if MdStartE=1, capture operands, op, sign flags (sA, sB) and magnitudes.
  - Signed sources: MUL/MULH/DIV/REM treat A and B as signed; MULHSU treats A as signed and B as unsigned; U-ops treat both as unsigned.
  - Special divides go straight to DONE with the result loaded:
    - divisor==0: quotient 0xFFFFFFFF; remainder = dividend.
    - signed DIV/REM with A=0x80000000, B=0xFFFFFFFF: quotient 0x80000000; remainder 0.
  - All other ops go to BUSY with counter=XLEN.

BUSY:
- One multiply step (add multiplicand if LSB set, shift a 2*XLEN product) or one restoring divide step per cycle. Counter decrements.
- When the counter reaches 1 on the current step, apply sign fixup and load MdResultE, then go to DONE.
- Multiply sign fixup: negate the 64-bit product if sA^sB; sB is forced to 0 for MULHSU/MULHU, and sA is forced to 0 for MULHU.
- Divide sign fixup: quotient sign = sA^sB; remainder sign = sA.
- Result select:
  - MUL = product[31:0]; MULH* = product[63:32].
  - DIV* = quotient; REM* = remainder.
- FlushE=1 in BUSY: go to IDLE next cycle with no done; MdResultE keeps its old value.

DONE:
- MdDoneE=1 and MdStallE=0, so the pipeline advances at this edge. The next state is unconditionally IDLE.
- FlushE in DONE suppresses MdDoneE (combinationally gated) and still goes to IDLE.
- MdStartE is ignored in DONE, because the same instruction is still in EX.

Stall and latency:
- MdStallE = (IDLE & MdStartE & ~FlushE) | BUSY. It is combinational from the state and inputs.
- Latency for normal ops: start accepted at edge T, BUSY for cycles T+1..T+XLEN, DONE at cycle T+XLEN+1. MdStallE is high from cycle T through T+XLEN.
- Latency for special divides: DONE at T+1, with MdStallE high only in cycle T.
- Back-to-back ops: a new MdStartE seen in the IDLE cycle after DONE starts a fresh op with no bubble beyond that IDLE cycle.

Other rules:
- Operands are sampled only in IDLE; later changes on SrcAE/SrcBE (forwarding updates) are ignored.
- MdResultE holds its value until the next load.
- Arithmetic: all internal adders are XLEN+1 bits wide. The product register is 2*XLEN. Negation is two's complement modulo the field width.

Test Plan:
1. MUL A=7, B=0xFFFFFFFD, start at T -> MdStallE high T..T+32; MdDoneE pulse at T+33; MdResultE=0xFFFFFFEB.
2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF. Each done at T+33.
3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2. Each done at T+33.
4. DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. All done at T+1 with MdStallE high only in cycle T.
5. Start DIVU at T, FlushE at T+10 -> IDLE at T+11, no MdDoneE, MdResultE unchanged. New MUL 3*4 started at T+11 -> 12 at T+44.
6. rst_n low at T+5 of a MUL -> all outputs 0 immediately and no later done. Two back-to-back MULs (2*3, then 5*6) -> done pulses at T+33 and T+67 with results 6 and 30.
